avalon_mem_sequencer: RTL and testbench
=======================================

Name: avalon_mem_sequencer

Overview:
- Synthesizable controller that shares the single Avalon-MM master port between the CPU's instruction-fetch and data ports.
- Sequences each instruction: fetch, optional data read and/or write, then a one-cycle commit strobe (cpu_enable) to advance the CPU.
- Sits between the mips_cpu harvard-style ports and the top-level Avalon bus.
- Replaces event-wait sequencing with a clocked FSM, and adds a waitrequest timeout.

Parameters:
- WAIT_LIMIT, 1023: consecutive waitrequest-high cycles tolerated per bus transfer before abort. 0 disables the timeout. Range 0..65535.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- cpu_active  input  1  CPU active flag; low means halted
- instr_address  input  32  CPU fetch address (PC)
- instr_readdata  output  32  registered fetched instruction to CPU
- data_address  input  32  CPU data address
- data_read  input  1  CPU requests load (combinational from instr_readdata)
- data_write  input  1  CPU requests store
- data_writedata  input  32  store data
- data_byteenable  input  4  store/load byte lanes
- data_readdata  output  32  registered load data to CPU
- cpu_enable  output  1  one-cycle commit strobe; CPU updates state only when high
- halted  output  1  sequencer stopped (CPU halt or bus error)
- bus_error  output  1  sticky; set on waitrequest timeout
- address  output  32  Avalon address
- read  output  1  Avalon read
- write  output  1  Avalon write
- byteenable  output  4  Avalon byte enables (4'b1111 for fetch)
- writedata  output  32  Avalon write data
- waitrequest  input  1  Avalon stall
- readdata  input  32  Avalon read data, valid in the cycle where read=1 and waitrequest=0

Behaviour:
- All outputs are registered.
- Reset values: every output 0; state IDLE; wait counter 0.
- Reset mid-transfer drops read/write on the next edge with no completion.
- States: IDLE, FETCH, DECODE, DRD, DWR, COMMIT, HALTED.
- IDLE:
  - cpu_active=1: read<=1, address<=instr_address, byteenable<=4'hF, go to FETCH.
  - Otherwise go to HALTED.
- FETCH:
  - Hold address/read while waitrequest=1.
  - On waitrequest=0: instr_readdata<=readdata, read<=0, go to DECODE.
- DECODE: one cycle so the CPU decodes the registered instruction.
  - data_read=1: read<=1, address<=data_address, byteenable<=data_byteenable, go to DRD.
  - Else data_write=1: write<=1, address, writedata, byteenable from the CPU, go to DWR.
  - Else: cpu_enable<=1, go to COMMIT.
- DRD:
  - On waitrequest=0: data_readdata<=readdata, read<=0.
  - If data_write is also high (sampled in DECODE and latched), the write is issued next cycle: go to DWR.
  - Otherwise cpu_enable<=1, go to COMMIT.
- DWR: on waitrequest=0: write<=0, cpu_enable<=1, go to COMMIT.
- COMMIT: cpu_enable high for exactly this cycle; cpu_enable<=0, go to IDLE. IDLE re-samples the post-commit cpu_active.
- HALTED:
  - halted=1, no bus activity, cpu_enable=0.
  - Exits only on reset.
- Avalon rules:
  - read and write are never both high.
  - address, writedata and byteenable are stable while waitrequest=1.
  - Never more than one outstanding transfer.
- Timeout:
  - A 16-bit counter increments each cycle read|write=1 with waitrequest=1, and clears on completion or on a new transfer.
  - When WAIT_LIMIT≠0 and the count reaches WAIT_LIMIT: drop read/write, set bus_error=1, go to HALTED; cpu_enable is not pulsed.
- Latency with zero wait states:
  - ALU instruction: 4 cycles (IDLE, FETCH, DECODE, COMMIT).
  - Load or store: 5 cycles.
  - Load+store: 6 cycles.
  - Each waitrequest cycle adds 1.
- data_read/data_write changing outside DECODE are ignored.

Test Plan:
- Reset held 3 cycles then released, instr_address=0xBFC00000, waitrequest=0, decoded ALU op -> read=1 at 0xBFC00000 for 1 cycle; cpu_enable pulses once, exactly 4 cycles per instruction; no write ever asserted.
- Fetch with waitrequest high 5 cycles -> address/read stable for 6 cycles; instr_readdata=readdata sampled on cycle 6; cpu_enable at cycle 9 after IDLE.
- Load: data_read=1, data_address=0x00001000, readdata=0xDEADBEEF -> second read at 0x1000; data_readdata=0xDEADBEEF before the cpu_enable pulse; 5-cycle instruction.
- Store: data_write=1, data_writedata=0x12345678, data_byteenable=4'b0011 -> write=1 with those values for 1 cycle; cpu_enable next cycle.
- WAIT_LIMIT=8, waitrequest stuck high during fetch -> read drops after 8 stall cycles; bus_error=1 and halted=1 thereafter; no cpu_enable; a subsequent reset clears both.
- cpu_active falls after a commit -> next state HALTED, no further fetch.
- Reset asserted mid-DRD -> read=0 next cycle; fetch restarts after release.

Source files
------------

// File: rtl/avalon_mem_sequencer.sv
// ---------------------------------------------------------------------------
// avalon_mem_sequencer
//
// Shares one Avalon-MM master port between a CPU's instruction-fetch and data
// ports. Each instruction runs as a fixed sequence:
//   IDLE -> FETCH -> DECODE -> [DRD] -> [DWR] -> COMMIT -> IDLE
// COMMIT is the single cycle in which cpu_enable is high. The CPU may update
// its architectural state only in that cycle.
//
// Any bus transfer that is stalled by waitrequest for WAIT_LIMIT consecutive
// cycles is aborted. bus_error is then set (sticky) and the sequencer parks in
// HALTED. A WAIT_LIMIT of 0 disables the timeout.
//
// Ports
//   clk, reset        : system clock; synchronous active-high reset
//   cpu_active        : CPU running flag (low = CPU has halted)
//   instr_address     : fetch address (PC) from the CPU
//   instr_readdata    : registered fetched instruction to the CPU
//   data_address      : load/store address from the CPU
//   data_read         : load request (decoded from instr_readdata)
//   data_write        : store request
//   data_writedata    : store data
//   data_byteenable   : byte lanes for the load/store
//   data_readdata     : registered load data to the CPU
//   cpu_enable        : one-cycle commit strobe
//   halted            : sequencer stopped (CPU halt or bus error)
//   bus_error         : sticky waitrequest-timeout flag
//   address, read, write, byteenable, writedata : Avalon master outputs
//   waitrequest, readdata                       : Avalon master inputs
// ---------------------------------------------------------------------------
module avalon_mem_sequencer #(
  parameter int unsigned WAIT_LIMIT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_active,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  input  logic [3:0]  data_byteenable,
  output logic [31:0] data_readdata,
  output logic        cpu_enable,
  output logic        halted,
  output logic        bus_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_DRD    = 3'd3,
    S_DWR    = 3'd4,
    S_COMMIT = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  // Limit widened to 17 bits so the "count + 1" comparison never wraps.
  localparam logic [16:0] LIMIT    = 17'(WAIT_LIMIT);
  localparam logic        LIMIT_EN = (WAIT_LIMIT != 0);

  state_t      state;
  logic [15:0] wait_count;
  logic        pending_write;   // store half of a load+store, latched in DECODE

  logic [16:0] count_inc;
  logic        timeout_hit;

  // The current stalled cycle is counted before comparing, so with a limit of
  // N the transfer is dropped after exactly N waitrequest-high cycles.
  always_comb begin
    count_inc   = {1'b0, wait_count} + 17'd1;
    timeout_hit = LIMIT_EN && (count_inc >= LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      wait_count     <= '0;
      pending_write  <= 1'b0;
      instr_readdata <= '0;
      data_readdata  <= '0;
      cpu_enable     <= 1'b0;
      halted         <= 1'b0;
      bus_error      <= 1'b0;
      address        <= '0;
      read           <= 1'b0;
      write          <= 1'b0;
      byteenable     <= '0;
      writedata      <= '0;
    end else begin
      // The commit strobe is only ever raised for a single cycle.
      cpu_enable <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cpu_active) begin
            read       <= 1'b1;
            address    <= instr_address;
            byteenable <= 4'hF;
            wait_count <= '0;
            state      <= S_FETCH;
          end else begin
            halted <= 1'b1;
            state  <= S_HALTED;
          end
        end

        S_FETCH: begin
          if (!waitrequest) begin
            instr_readdata <= readdata;
            read           <= 1'b0;
            wait_count     <= '0;
            state          <= S_DECODE;
          end else if (timeout_hit) begin
            read       <= 1'b0;
            write      <= 1'b0;
            bus_error  <= 1'b1;
            halted     <= 1'b1;
            wait_count <= '0;
            state      <= S_HALTED;
          end else begin
            wait_count <= count_inc[15:0];
          end
        end

        // The CPU decodes the registered instruction during this cycle; its
        // data_read/data_write requests are only honoured here.
        S_DECODE: begin
          pending_write <= data_write;
          wait_count    <= '0;
          if (data_read) begin
            read       <= 1'b1;
            address    <= data_address;
            byteenable <= data_byteenable;
            state      <= S_DRD;
          end else if (data_write) begin
            write      <= 1'b1;
            address    <= data_address;
            writedata  <= data_writedata;
            byteenable <= data_byteenable;
            state      <= S_DWR;
          end else begin
            cpu_enable <= 1'b1;
            state      <= S_COMMIT;
          end
        end

        S_DRD: begin
          if (!waitrequest) begin
            data_readdata <= readdata;
            read          <= 1'b0;
            wait_count    <= '0;
            if (pending_write) begin
              // Read drops and write rises on the same edge, so the two
              // strobes never overlap and no idle cycle is inserted.
              write      <= 1'b1;
              address    <= data_address;
              writedata  <= data_writedata;
              byteenable <= data_byteenable;
              state      <= S_DWR;
            end else begin
              cpu_enable <= 1'b1;
              state      <= S_COMMIT;
            end
          end else if (timeout_hit) begin
            read       <= 1'b0;
            write      <= 1'b0;
            bus_error  <= 1'b1;
            halted     <= 1'b1;
            wait_count <= '0;
            state      <= S_HALTED;
          end else begin
            wait_count <= count_inc[15:0];
          end
        end

        S_DWR: begin
          if (!waitrequest) begin
            write      <= 1'b0;
            wait_count <= '0;
            cpu_enable <= 1'b1;
            state      <= S_COMMIT;
          end else if (timeout_hit) begin
            read       <= 1'b0;
            write      <= 1'b0;
            bus_error  <= 1'b1;
            halted     <= 1'b1;
            wait_count <= '0;
            state      <= S_HALTED;
          end else begin
            wait_count <= count_inc[15:0];
          end
        end

        // cpu_enable is high during this cycle (default above clears it);
        // IDLE then re-samples cpu_active as updated by the commit.
        S_COMMIT: begin
          state <= S_IDLE;
        end

        // Terminal until reset: no bus activity.
        S_HALTED: begin
          halted <= 1'b1;
          read   <= 1'b0;
          write  <= 1'b0;
        end

        default: begin
          read  <= 1'b0;
          write <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_mem_sequencer.sv
// Testbench for avalon_mem_sequencer: a small CPU model (PC + decode of the
// fetched word) and an Avalon slave with random wait states. Expected bus
// transfers, latencies and returned data are derived per instruction from
// the instruction word itself.
module tb_avalon_mem_sequencer;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_active;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic [31:0] data_readdata;
  logic        cpu_enable;
  logic        halted;
  logic        bus_error;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  avalon_mem_sequencer #(.WAIT_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .cpu_active(cpu_active),
    .instr_address(instr_address), .instr_readdata(instr_readdata),
    .data_address(data_address), .data_read(data_read), .data_write(data_write),
    .data_writedata(data_writedata), .data_byteenable(data_byteenable),
    .data_readdata(data_readdata), .cpu_enable(cpu_enable), .halted(halted),
    .bus_error(bus_error), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // CPU model: PC advances on commit; memory ops decoded from the instruction.
  logic [31:0] imem [64];
  logic [31:0] pc;
  assign instr_address   = pc;
  assign data_read       = instr_readdata[31];
  assign data_write      = instr_readdata[30];
  assign data_address    = {16'h0000, instr_readdata[15:2], 2'b00};
  assign data_byteenable = instr_readdata[19:16];
  assign data_writedata  = {instr_readdata[15:0], instr_readdata[31:16]} ^ 32'h5A5A5A5A;

  always @(posedge clk) begin
    if (reset) pc <= BASE;
    else if (cpu_enable) pc <= pc + 32'd4;
  end

  // Slave bookkeeping
  bit          in_xfer;
  int          stall_left;
  logic [31:0] snap_addr, snap_wd, rd_val;
  logic [3:0]  snap_be;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_active = 1'b1;
    waitrequest = 1'b0;
    readdata = '0;
    in_xfer = 0;
    stall_left = 0;
    repeat (3) tick();
    check("rst_read", 32'(read), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_cpu_enable", 32'(cpu_enable), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_byteenable", 32'(byteenable), 32'd0);
    check("rst_writedata", writedata, 32'd0);
    check("rst_instr_readdata", instr_readdata, 32'd0);
    check("rst_data_readdata", data_readdata, 32'd0);
    reset = 1'b0;
  endtask

  // Runs one instruction starting in IDLE. fstall >= 0 forces the fetch stall
  // count; other transfers get 0..maxst random stall cycles.
  task automatic run_instr(input int fstall, input int maxst);
    logic [31:0] ins, daddr, wdata;
    logic [3:0]  dbe;
    logic [31:0] e_addr [3];
    logic        e_rd   [3];
    logic [3:0]  e_be   [3];
    logic [31:0] e_wd   [3];
    int n, idx, cyc, stalls;
    bit done;
    ins   = imem[pc[7:2]];
    daddr = {16'h0000, ins[15:2], 2'b00};
    dbe   = ins[19:16];
    wdata = {ins[15:0], ins[31:16]} ^ 32'h5A5A5A5A;
    e_addr[0] = pc; e_rd[0] = 1'b1; e_be[0] = 4'hF; e_wd[0] = '0;
    n = 1;
    if (ins[31]) begin
      e_addr[n] = daddr; e_rd[n] = 1'b1; e_be[n] = dbe; e_wd[n] = '0; n++;
    end
    if (ins[30]) begin
      e_addr[n] = daddr; e_rd[n] = 1'b0; e_be[n] = dbe; e_wd[n] = wdata; n++;
    end
    idx = 0; cyc = 0; stalls = 0; done = 0;
    while (!done && cyc < 200) begin
      check("no_rd_wr_overlap", 32'(read & write), 32'd0);
      if (read || write) begin
        if (!in_xfer) begin
          if (idx < n) begin
            check("xfer_addr", address, e_addr[idx]);
            check("xfer_is_read", 32'(read), 32'(e_rd[idx]));
            check("xfer_be", 32'(byteenable), 32'(e_be[idx]));
            if (!e_rd[idx]) check("xfer_wdata", writedata, e_wd[idx]);
          end else begin
            check("unexpected_xfer", 32'(idx), 32'(n - 1));
          end
          in_xfer    = 1;
          snap_addr  = address;
          snap_be    = byteenable;
          snap_wd    = writedata;
          stall_left = (idx == 0 && fstall >= 0) ? fstall : int'($urandom_range(maxst, 0));
          stalls    += stall_left;
          rd_val     = (idx == 0) ? ins : $urandom;
        end else begin
          check("stall_addr_stable", address, snap_addr);
          check("stall_be_stable", 32'(byteenable), 32'(snap_be));
          if (write) check("stall_wd_stable", writedata, snap_wd);
        end
        waitrequest = (stall_left != 0);
        readdata    = waitrequest ? $urandom : rd_val;
      end else begin
        waitrequest = 1'b0;
        readdata    = $urandom;
      end
      tick();
      cyc++;
      if (in_xfer) begin
        if (!waitrequest) begin
          in_xfer = 0;
          if (idx == 0) check("instr_readdata", instr_readdata, rd_val);
          else if (idx < n && e_rd[idx]) check("data_readdata", data_readdata, rd_val);
          idx++;
        end else begin
          stall_left--;
        end
      end
      if (cpu_enable) done = 1;
    end
    check("commit_seen", 32'(done), 32'd1);
    check("instr_cycles", 32'(cyc), 32'(3 + (n - 1) + stalls));
    check("all_xfers_done", 32'(idx), 32'(n));
    waitrequest = 1'b0;
    tick();
    check("cpu_enable_one_cycle", 32'(cpu_enable), 32'd0);
    check("idle_no_read", 32'(read), 32'd0);
  endtask

  initial begin
    int cnt;
    bit saw_en;
    logic [31:0] ld_addr;

    for (int i = 0; i < 64; i++) imem[i] = $urandom;
    imem[0][31:30] = 2'b00;   // ALU
    imem[1][31:30] = 2'b10;   // load
    imem[2][31:30] = 2'b01;   // store
    imem[3][31:30] = 2'b11;   // load + store

    // Directed: ALU, load with 5-cycle fetch stall, store, load+store.
    do_reset();
    run_instr(0, 0);
    run_instr(5, 0);
    run_instr(-1, 0);
    run_instr(-1, 0);
    // Random mix with random wait states.
    for (int i = 0; i < 30; i++) run_instr(-1, 3);

    // CPU halts after a commit: no further fetch.
    cpu_active = 1'b0;
    tick();
    check("halt_flag", 32'(halted), 32'd1);
    cpu_active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("halt_no_read", 32'(read), 32'd0);
      check("halt_no_enable", 32'(cpu_enable), 32'd0);
      check("halt_stays", 32'(halted), 32'd1);
    end
    check("halt_no_bus_error", 32'(bus_error), 32'd0);

    // Reset in the middle of a data read.
    do_reset();
    run_instr(0, 0);                       // ALU at BASE; next is the load
    ld_addr = {16'h0000, imem[1][15:2], 2'b00};
    waitrequest = 1'b0;
    tick();                                // FETCH
    readdata = imem[1];
    tick();                                // DECODE
    tick();                                // DRD
    check("drd_read", 32'(read), 32'd1);
    check("drd_addr", address, ld_addr);
    waitrequest = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("mid_drd_reset_read", 32'(read), 32'd0);
    check("mid_drd_reset_write", 32'(write), 32'd0);
    reset = 1'b0;
    waitrequest = 1'b0;
    in_xfer = 0;
    run_instr(0, 0);                       // fetch restarts at BASE

    // Waitrequest stuck high during a fetch: timeout after 8 stall cycles.
    do_reset();
    waitrequest = 1'b1;
    cnt = 0;
    saw_en = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (read) cnt++;
      if (cpu_enable) saw_en = 1;
    end
    check("timeout_read_cycles", 32'(cnt), 32'd8);
    check("timeout_read_low", 32'(read), 32'd0);
    check("timeout_bus_error", 32'(bus_error), 32'd1);
    check("timeout_halted", 32'(halted), 32'd1);
    check("timeout_no_enable", 32'(saw_en), 32'd0);

    // Reset clears the error and the sequencer runs again.
    do_reset();
    run_instr(-1, 3);
    run_instr(-1, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
